// File: rtl/cic_comb_chain.sv
// ============================================================================
// Module      : cic_comb_chain
// Description : Cascaded, channel-interleaved CIC comb section (y = x - x[n-M])
//               with valid/ready flow control and a runtime differential delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comb_chain #(
  parameter int WIDTH     = 32,
  parameter int N_STAGES  = 4,
  parameter int N_CH      = 4,
  parameter int MAX_DELAY = 2,
  localparam int c_ch_w   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int c_dsel_w = $clog2(MAX_DELAY)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clr_i,
  input  logic [c_dsel_w-1:0] delay_sel_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [c_ch_w-1:0]   in_ch_i,
  input  logic [WIDTH-1:0]    in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [c_ch_w-1:0]   out_ch_o,
  output logic [WIDTH-1:0]    out_data_o,
  output logic                err_o
);

  localparam int                c_n_slots = N_STAGES * N_CH;
  localparam logic [c_ch_w:0]   c_n_ch    = (c_ch_w + 1)'(N_CH);

  // Packed history line: element [0] is the newest sample, [M-1] is the tap.
  typedef logic [MAX_DELAY-1:0][WIDTH-1:0] hist_t;

  hist_t                r_hist [c_n_slots];
  logic [N_STAGES-1:0]  r_vld;
  logic [c_ch_w-1:0]    r_ch   [N_STAGES];
  logic [WIDTH-1:0]     r_dat  [N_STAGES];
  logic                 r_err;

  logic [N_STAGES-1:0]  w_in_vld;
  logic [c_ch_w-1:0]    w_in_ch  [N_STAGES];
  logic [WIDTH-1:0]     w_in_dat [N_STAGES];
  logic [WIDTH-1:0]     w_tap    [N_STAGES];
  logic [WIDTH-1:0]     w_res    [N_STAGES];
  logic                 w_advance;
  logic                 w_ch_ok;
  logic                 w_accept;

  assign w_advance   = !r_vld[N_STAGES-1] || out_ready_i;
  assign in_ready_o  = w_advance && !clr_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_ch_ok     = {1'b0, in_ch_i} < c_n_ch;

  assign out_valid_o = r_vld[N_STAGES-1];
  assign out_ch_o    = r_ch[N_STAGES-1];
  assign out_data_o  = r_dat[N_STAGES-1];
  assign err_o       = r_err;

  // Stage inputs: stage 0 takes the accepted sample (bad tags become bubbles).
  always_comb begin
    w_in_vld    = '0;
    w_in_vld[0] = w_accept && w_ch_ok;
    w_in_ch[0]  = in_ch_i;
    w_in_dat[0] = in_data_i;
    for (int s = 1; s < N_STAGES; s++) begin
      w_in_vld[s] = r_vld[s-1];
      w_in_ch[s]  = r_ch[s-1];
      w_in_dat[s] = r_dat[s-1];
    end
    for (int s = 0; s < N_STAGES; s++) begin
      w_tap[s] = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (w_in_ch[s] == c_ch_w'(c)) begin
          w_tap[s] = r_hist[s*N_CH + c][delay_sel_i];
        end
      end
      w_res[s] = w_in_dat[s] - w_tap[s];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      r_vld <= '0;
      r_err <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        r_ch[s]  <= '0;
        r_dat[s] <= '0;
      end
      for (int i = 0; i < c_n_slots; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      if (w_accept && !w_ch_ok) begin
        r_err <= 1'b1;
      end
      if (w_advance) begin
        r_vld <= w_in_vld;
        for (int s = 0; s < N_STAGES; s++) begin
          if (w_in_vld[s]) begin
            r_ch[s]  <= w_in_ch[s];
            r_dat[s] <= w_res[s];
            for (int c = 0; c < N_CH; c++) begin
              if (w_in_ch[s] == c_ch_w'(c)) begin
                r_hist[s*N_CH + c] <= {r_hist[s*N_CH + c][MAX_DELAY-2:0], w_in_dat[s]};
              end
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_comb_chain.sv
// ============================================================================
// Module      : tb_cic_comb_chain
// Description : Randomised and directed checks of cic_comb_chain against a
//               binomial-expansion reference model with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_comb_chain;

  localparam int NS   = 3;
  localparam int NCH  = 3;
  localparam int MAXD = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic [0:0]  dsel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ch = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch;
  logic [31:0] out_data;
  logic        err;

  logic        b_clr = 1'b0;
  logic [0:0]  b_dsel = '0;
  logic        b_valid = 1'b0;
  logic        b_in_ready;
  logic [0:0]  b_ch = '0;
  logic [7:0]  b_data = '0;
  logic        b_out_valid;
  logic        b_ready = 1'b1;
  logic [0:0]  b_out_ch;
  logic [7:0]  b_out_data;
  logic        b_err;

  cic_comb_chain #(.WIDTH(32), .N_STAGES(NS), .N_CH(NCH), .MAX_DELAY(MAXD)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .delay_sel_i(dsel),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
    .out_data_o(out_data), .err_o(err)
  );

  cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .N_CH(1), .MAX_DELAY(2)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(b_clr), .delay_sel_i(b_dsel),
    .in_valid_i(b_valid), .in_ready_o(b_in_ready), .in_ch_i(b_ch), .in_data_i(b_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_ready), .out_ch_o(b_out_ch),
    .out_data_o(b_out_data), .err_o(b_err)
  );

  always #5 clk = ~clk;

  // Reference state: raw per-channel input history since the last clear.
  logic [31:0] xs [NCH][1024];
  int          n_x [NCH];
  logic [33:0] exp_q [$];
  logic [31:0] got_d [$];
  logic [1:0]  got_c [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  int          first_acc = -1;
  int          first_out = -1;
  bit          err_m = 1'b0;
  bit          stall_prev = 1'b0;
  bit          clr_prev = 1'b0;
  logic [31:0] prev_dat = '0;
  logic [1:0]  prev_ch = '0;

  int exp_m1 [8] = '{1, -3, 3, -1, 0, 0, 0, 0};
  int exp_m2 [8] = '{1, 0, -3, 0, 3, 0, -1, 0};
  int exp_c0 [4] = '{5, -10, 5, 0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // N cascaded combs of delay M == sum_k (-1)^k C(N,k) x[n-kM].
  function automatic logic [31:0] ref_y(input int c);
    int          m;
    int          n;
    int          b;
    int          idx;
    logic [31:0] acc;
    m   = int'(dsel) + 1;
    n   = n_x[c];
    b   = 1;
    acc = '0;
    for (int k = 0; k <= NS; k++) begin
      idx = n - 1 - k * m;
      if (idx >= 0) begin
        if (k % 2 == 1) acc = acc - 32'(b) * xs[c][idx];
        else            acc = acc + 32'(b) * xs[c][idx];
      end
      b = b * (NS - k) / (k + 1);
    end
    return acc;
  endfunction

  task automatic cyc();
    logic [33:0] e;
    int          ch;
    @(negedge clk);
    if (clr_prev) check_val("clear_out_valid", 32'(out_valid), 32'd0);
    if (stall_prev) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_data", out_data, prev_dat);
      check_val("stall_ch", 32'(out_ch), 32'(prev_ch));
    end
    check_val("err_flag", 32'(err), 32'(err_m));
    if (rstn && !clr) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_data", out_data, e[31:0]);
          check_val("out_ch", 32'(out_ch), 32'(e[33:32]));
        end
        got_d.push_back(out_data);
        got_c.push_back(out_ch);
        if (first_out < 0) first_out = cyc_n;
      end
      if (in_valid && in_ready) begin
        ch = int'(in_ch);
        if (ch < NCH) begin
          if (n_x[ch] < 1024) begin
            xs[ch][n_x[ch]] = in_data;
            n_x[ch]++;
          end
          exp_q.push_back({in_ch, ref_y(ch)});
          if (first_acc < 0) first_acc = cyc_n;
        end else begin
          err_m = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_ch    = out_ch;
      clr_prev   = 1'b0;
    end else begin
      if (clr) check_val("clear_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      for (int c = 0; c < NCH; c++) n_x[c] = 0;
      err_m      = 1'b0;
      stall_prev = 1'b0;
      clr_prev   = 1'b1;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [31:0] d);
    in_valid = v;
    in_ch    = ch;
    in_data  = d;
    cyc();
  endtask

  task automatic do_clr(input logic [0:0] ds);
    clr      = 1'b1;
    dsel     = ds;
    in_valid = 1'b0;
    cyc();
    clr = 1'b0;
  endtask

  task automatic start_dir();
    got_d.delete();
    got_c.delete();
    first_acc = -1;
    first_out = -1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
    check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
    cyc();
    cyc();
  endtask

  task automatic cmp_list(input string tag, input int expv [8], input int n);
    check_val({tag, "_count"}, 32'(got_d.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_d.size()) check_val(tag, got_d[i], 32'(expv[i]));
    end
  endtask

  task automatic impulse(input int len);
    start_dir();
    drive(1'b1, 2'd0, 32'd1);
    for (int i = 1; i < len; i++) drive(1'b1, 2'd0, 32'd0);
    drain();
  endtask

  initial begin
    int i0;
    int i1;
    for (int c = 0; c < NCH; c++) n_x[c] = 0;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_out_ch", 32'(out_ch), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 8-bit single stage wrap-around
    b_valid = 1'b1;
    b_data  = 8'h80;
    @(posedge clk);
    #1;
    b_data = 8'h7F;
    @(negedge clk);
    check_val("wrap_valid0", 32'(b_out_valid), 32'd1);
    check_val("wrap_data0", 32'(b_out_data), 32'h80);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(negedge clk);
    check_val("wrap_valid1", 32'(b_out_valid), 32'd1);
    check_val("wrap_data1", 32'(b_out_data), 32'hFF);
    @(posedge clk);
    #1;

    dsel = 1'b0;
    impulse(5);
    cmp_list("impulse_m1", exp_m1, 5);
    check_val("latency", 32'(first_out - first_acc), 32'd3);

    do_clr(1'b1);
    impulse(8);
    cmp_list("impulse_m2", exp_m2, 8);

    do_clr(1'b0);
    start_dir();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 32'd5);
      drive(1'b1, 2'd1, 32'd0);
    end
    drain();
    i0 = 0;
    i1 = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_c[i] == 2'd0) begin
        if (i0 < 4) check_val("ilv_ch0", got_d[i], 32'(exp_c0[i0]));
        i0++;
      end else if (got_c[i] == 2'd1) begin
        check_val("ilv_ch1", got_d[i], 32'd0);
        i1++;
      end else begin
        check_val("ilv_tag", 32'(got_c[i]), 32'd0);
      end
    end
    check_val("ilv_n0", 32'(i0), 32'd4);
    check_val("ilv_n1", 32'(i1), 32'd4);

    // clear mid-stream with a sample presented
    drive(1'b1, 2'd0, 32'd7);
    drive(1'b1, 2'd0, 32'd9);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    cyc();
    clr = 1'b0;
    impulse(5);
    cmp_list("clear_impulse", exp_m1, 5);

    // out-of-range channel
    start_dir();
    drive(1'b1, 2'd3, 32'd55);
    drive(1'b0, 2'd0, 32'd0);
    drive(1'b0, 2'd0, 32'd0);
    check_val("err_sticky", 32'(err), 32'd1);
    drain();
    check_val("bad_ch_no_out", 32'(got_d.size()), 32'd0);
    check_val("err_held", 32'(err), 32'd1);
    do_clr(1'b0);
    check_val("err_cleared", 32'(err), 32'd0);

    // randomised traffic with backpressure
    for (int p = 0; p < 6; p++) begin
      do_clr(1'($urandom_range(0, 1)));
      for (int i = 0; i < 250; i++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              $urandom);
      end
      drain();
    end

    // reset mid-stream under backpressure
    do_clr(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 2'($urandom_range(0, 2)), $urandom);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_data", out_data, 32'd0);
    check_val("midrst_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b1;
    impulse(5);
    cmp_list("post_reset_impulse", exp_m1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
Multi-stage, multi-channel comb section for the CIC decimator datapath. It sits after the decimating integrator section and ahead of the output formatter. It computes y = x - x[n-M] for N_STAGES cascaded stages on a time-multiplexed stream of up to N_CH channels. Differential delay M is runtime-selectable from 1 to MAX_DELAY, and the block supports valid/ready flow control in both directions.

Parameters:
WIDTH, 32, sample width in bits, two's complement, modular arithmetic
N_STAGES, 4, number of cascaded comb stages (>=1)
N_CH, 4, number of interleaved channels (>=1)
MAX_DELAY, 2, maximum differential delay M (>=2, power of two)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, synchronous, active-low
clr_i  in  1  synchronous clear of all history, pipeline and error state
delay_sel_i  in  $clog2(MAX_DELAY)  M = delay_sel_i+1; must be static while any sample is in flight
in_valid_i  in  1  input sample valid
in_ready_o  out  1  block accepts the input sample this cycle
in_ch_i  in  $clog2(N_CH) (min 1)  channel tag of the input sample
in_data_i  in  WIDTH  input sample
out_valid_o  out  1  output sample valid
out_ready_i  in  1  downstream accepts the output sample
out_ch_o  out  $clog2(N_CH) (min 1)  channel tag of the output sample
out_data_o  out  WIDTH  comb-chain result
err_o  out  1  sticky flag: a sample arrived with in_ch_i >= N_CH

Behaviour:
- Reset: rstn_i low at a clock edge clears history, pipeline valid bits, data/tag registers and err_o.
  - Outputs after reset: out_valid_o=0, out_data_o=0, out_ch_o=0, err_o=0, in_ready_o=1.
  - Reset mid-stream discards all in-flight samples.
- clr_i high: same clearing effect as reset, with in_ready_o=0 that cycle. A sample presented with clr_i is not accepted. rstn_i has priority over clr_i.
- Pipeline: one register stage per comb stage. Each stage holds valid, channel tag and data.
  - Global advance = !out_valid_o || out_ready_i.
  - in_ready_o = advance && !clr_i.
  - Accept = in_valid_i && in_ready_o.
  - Latency is N_STAGES cycles from accept to out_valid_o when there is no backpressure. Throughput is 1 sample/cycle.
- Stall: when advance=0, all stage registers and history hold. Output data and tag stay stable while out_valid_o=1 and out_ready_i=0.
- History: per stage s, per channel c, a MAX_DELAY-deep shift register h[s][c][0..MAX_DELAY-1], where h[0] is the newest.
  - When a valid sample x for channel c moves through stage s: result = x - h[s][c][M-1].
  - Shift: h[s][c][0] <= x, and h[k] <= h[k-1].
  - Only the addressed channel's history changes. Bubbles (valid=0) change nothing.
- Arithmetic: subtraction is modulo 2^WIDTH with no saturation; wrap-around is intended, since CIC gain relies on it.
- Invalid channel: an accepted sample with in_ch_i >= N_CH is consumed and dropped.
  - It produces no output and updates no history.
  - err_o is set the next cycle and stays set until clr_i or reset.
- Delay change: a change of delay_sel_i takes effect immediately for later samples, and the history is not rescaled. Software must clear with clr_i after changing M. Behaviour without that clear is defined (old history is used) but not meaningful.
- Channels are independent: any interleave order, including repeated back-to-back samples of the same channel, gives per-channel results identical to a single-channel run.

Test Plan:
- N_STAGES=3, M=1, ch0 impulse 1 then zeros -> out 1, -3, 3, -1, 0; first output valid 3 cycles after accept.
- N_STAGES=3, M=2, ch0 impulse 1 then zeros -> out 1, 0, -3, 0, 3, 0, -1, 0.
- N_STAGES=3, M=1, ch0 step of 5 interleaved with ch1 constant 0 (alternating tags) -> ch0 outputs 5, -10, 5, 0...; ch1 outputs all 0; tags preserved.
- WIDTH=8, N_STAGES=1, M=1, inputs 0x80 then 0x7F -> out 0x80, 0xFF.
- Random stream with out_ready_i toggling randomly -> outputs match a reference model, no loss or duplication, out_data_o stable while stalled.
- clr_i pulsed mid-stream with in_valid_i=1 -> that sample not accepted, out_valid_o=0 next cycle, next impulse reproduces the clean response. in_ch_i=N_CH sample -> no output, err_o=1 until clr_i.
